// File: rtl/cache_pkg.sv
// Shared definitions for the trace player and its cache-side neighbours:
// op byte encodings, player FSM states and the request record.
package cache_pkg;

  localparam int REQ_ADDR_W = 32;

  localparam logic [7:0] OP_READ  = 8'h52;  // ASCII 'R'
  localparam logic [7:0] OP_WRITE = 8'h57;  // ASCII 'W'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_RESP,
    ST_DONE
  } player_state_e;

  typedef struct packed {
    logic                  write;
    logic [REQ_ADDR_W-1:0] addr;
  } req_t;

endpackage

// File: rtl/trace_player_if.sv
// Request/response channel between the trace player (master) and the cache (slave).
interface trace_player_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              resp_valid;
  logic              resp_hit;

  modport master (
    output req_valid, req_write, req_addr,
    input  req_ready, resp_valid, resp_hit
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    output req_ready, resp_valid, resp_hit
  );
endinterface

// File: rtl/trace_player_stats.sv
// Replay statistics: five independent event counters with a common clear.
module trace_stats #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc_rd,
  input  logic             inc_wr,
  input  logic             inc_hit,
  input  logic             inc_miss,
  input  logic             inc_bad,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] bad_count
);

  // Count one event per strobe; clear wins so a restart always begins at zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_count   <= '0;
      wr_count   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      bad_count  <= '0;
    end else begin
      if (inc_rd)   rd_count   <= rd_count   + CNT_W'(1);
      if (inc_wr)   wr_count   <= wr_count   + CNT_W'(1);
      if (inc_hit)  hit_count  <= hit_count  + CNT_W'(1);
      if (inc_miss) miss_count <= miss_count + CNT_W'(1);
      if (inc_bad)  bad_count  <= bad_count  + CNT_W'(1);
    end
  end

endmodule

// File: rtl/trace_player.sv
// Trace replay sequencer: walks the op/address tables, issues one cache
// request per legal entry, waits for its response and gathers statistics.
module trace_player
  import cache_pkg::*;
#(
  parameter int SIZE   = 1000,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = $clog2(SIZE),
  parameter int CNT_W  = $clog2(SIZE + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [IDX_W-1:0]  trace_idx,
  input  logic [7:0]        op_data,
  input  logic [ADDR_W-1:0] addr_data,
  trace_player_if.master    bus,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [CNT_W-1:0]  bad_count
);

  player_state_e state, state_d;

  logic clear;
  logic load_req;
  logic advance;
  logic last_entry;
  logic handshake;
  logic inc_rd, inc_wr, inc_hit, inc_miss, inc_bad;

  assign last_entry = (trace_idx == IDX_W'(SIZE - 1));
  // req_valid is only ever high in ISSUE, so this is the accepting edge.
  assign handshake  = bus.req_valid & bus.req_ready;

  assign busy = (state == ST_FETCH) || (state == ST_ISSUE) || (state == ST_WAIT_RESP);
  assign done = (state == ST_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Next-state decode and per-cycle event strobes.
  always_comb begin
    state_d  = state;
    clear    = 1'b0;
    load_req = 1'b0;
    advance  = 1'b0;
    inc_rd   = 1'b0;
    inc_wr   = 1'b0;
    inc_hit  = 1'b0;
    inc_miss = 1'b0;
    inc_bad  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (op_data == OP_READ || op_data == OP_WRITE) begin
          load_req = 1'b1;
          state_d  = ST_ISSUE;
        end else begin
          // Unknown op: count it and move on without touching the cache.
          inc_bad = 1'b1;
          advance = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (handshake) begin
          inc_rd  = ~bus.req_write;
          inc_wr  = bus.req_write;
          state_d = ST_WAIT_RESP;
        end
      end
      ST_WAIT_RESP: begin
        if (bus.resp_valid) begin
          inc_hit  = bus.resp_hit;
          inc_miss = ~bus.resp_hit;
          advance  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (advance) state_d = last_entry ? ST_DONE : ST_FETCH;
  end

  // Trace index and the registered request held stable until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      trace_idx     <= '0;
      bus.req_valid <= 1'b0;
      bus.req_write <= 1'b0;
      bus.req_addr  <= '0;
    end else begin
      if (clear) begin
        trace_idx <= '0;
      end else if (advance && !last_entry) begin
        trace_idx <= trace_idx + IDX_W'(1);
      end
      if (load_req) begin
        bus.req_valid <= 1'b1;
        bus.req_write <= (op_data == OP_WRITE);
        bus.req_addr  <= addr_data;
      end else if (handshake) begin
        bus.req_valid <= 1'b0;
      end
    end
  end

  trace_stats #(
    .CNT_W (CNT_W)
  ) u_stats (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .inc_rd     (inc_rd),
    .inc_wr     (inc_wr),
    .inc_hit    (inc_hit),
    .inc_miss   (inc_miss),
    .inc_bad    (inc_bad),
    .rd_count   (rd_count),
    .wr_count   (wr_count),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .bad_count  (bad_count)
  );

endmodule

// File: tb/tb_trace_player.sv
// Bench for trace_player: a 4-entry instance driven from a vector table plus
// hand-written corner sequences, and a 1000-entry instance with a random responder.
module tb_trace_player;

  logic clk;
  logic rst;

  int total = 0;
  int bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- small instance (SIZE=4) ----------------
  logic             s_start;
  logic [1:0]       s_idx;
  logic [7:0]       s_op;
  logic [31:0]      s_addr;
  logic             s_busy, s_done;
  logic [2:0]       s_rd, s_wr, s_hit, s_miss, s_bad;
  logic [3:0][7:0]  s_ops;
  logic [3:0]       s_hits;
  int               s_lat;
  int               s_timer;
  int               s_stall_idx;
  int               s_stall_left;
  int               s_req_seen;

  trace_player_if #(.ADDR_W(32)) s_bus ();

  assign s_op   = s_ops[s_idx];
  assign s_addr = 32'h10 + {30'h0, s_idx};

  trace_player #(.SIZE(4), .ADDR_W(32)) dut_s (
    .clk        (clk),
    .rst        (rst),
    .start      (s_start),
    .trace_idx  (s_idx),
    .op_data    (s_op),
    .addr_data  (s_addr),
    .bus        (s_bus.master),
    .busy       (s_busy),
    .done       (s_done),
    .rd_count   (s_rd),
    .wr_count   (s_wr),
    .hit_count  (s_hit),
    .miss_count (s_miss),
    .bad_count  (s_bad)
  );

  // Small responder: optional ready stall on one entry, response s_lat cycles after acceptance.
  initial begin
    s_bus.req_ready  = 1'b1;
    s_bus.resp_valid = 1'b0;
    s_bus.resp_hit   = 1'b0;
    s_timer          = 0;
    forever begin
      @(negedge clk);
      s_bus.resp_valid = 1'b0;
      if (s_timer > 0) begin
        s_timer--;
        if (s_timer == 0) begin
          s_bus.resp_valid = 1'b1;
          s_bus.resp_hit   = s_hits[s_idx];
        end
      end
      if (s_bus.req_valid && int'(s_idx) == s_stall_idx && s_stall_left > 0) begin
        check("stall_valid", int'(s_bus.req_valid), 1);
        check("stall_write", int'(s_bus.req_write), int'(s_ops[s_idx] == 8'h57));
        check("stall_addr", int'(s_bus.req_addr), 32'h10 + int'(s_idx));
        check("stall_wr_count", int'(s_wr), 0);
        s_bus.req_ready = 1'b0;
        s_stall_left--;
      end else begin
        s_bus.req_ready = 1'b1;
      end
      if (s_bus.req_valid && s_bus.req_ready && !rst) begin
        check("req_write", int'(s_bus.req_write), int'(s_ops[s_idx] == 8'h57));
        check("req_addr", int'(s_bus.req_addr), 32'h10 + int'(s_idx));
        s_req_seen++;
        s_timer = s_lat;
      end
    end
  end

  // ---------------- large instance (SIZE=1000) ----------------
  logic        b_start;
  logic [9:0]  b_idx;
  logic [7:0]  b_op;
  logic [31:0] b_addr;
  logic        b_busy, b_done;
  logic [9:0]  b_rd, b_wr, b_hit, b_miss, b_bad;
  int          b_timer;
  int          b_reqs;
  int          b_resps;
  int          b_hits_exp;
  logic        b_h;

  trace_player_if #(.ADDR_W(32)) b_bus ();

  assign b_op   = (int'(b_idx) % 3 == 0) ? 8'h57 : 8'h52;
  assign b_addr = {20'h0, b_idx, 2'b00};

  trace_player #(.SIZE(1000), .ADDR_W(32)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .start      (b_start),
    .trace_idx  (b_idx),
    .op_data    (b_op),
    .addr_data  (b_addr),
    .bus        (b_bus.master),
    .busy       (b_busy),
    .done       (b_done),
    .rd_count   (b_rd),
    .wr_count   (b_wr),
    .hit_count  (b_hit),
    .miss_count (b_miss),
    .bad_count  (b_bad)
  );

  // Large responder: random ready, random 1..3 cycle response latency, random hit.
  initial begin
    b_bus.req_ready  = 1'b0;
    b_bus.resp_valid = 1'b0;
    b_bus.resp_hit   = 1'b0;
    b_timer = 0; b_reqs = 0; b_resps = 0; b_hits_exp = 0;
    forever begin
      @(negedge clk);
      b_bus.resp_valid = 1'b0;
      if (b_timer > 0) begin
        b_timer--;
        if (b_timer == 0) begin
          b_h = ($urandom_range(0, 1) == 1);
          b_bus.resp_valid = 1'b1;
          b_bus.resp_hit   = b_h;
          b_resps++;
          if (b_h) b_hits_exp++;
        end
      end
      b_bus.req_ready = ($urandom_range(0, 3) != 0);
      if (b_bus.req_valid && b_bus.req_ready) begin
        b_reqs++;
        b_timer = int'($urandom_range(1, 3));
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    string           name;
    logic [3:0][7:0] ops;
    logic [3:0]      hits;
    int              stall_idx;
    int              cyc, rd, wr, hit, miss, bad;
  } vec_t;

  vec_t vecs[5];

  task automatic set_vec(input int i, input string name, input logic [3:0][7:0] ops,
                         input logic [3:0] hits, input int stall_idx, input int cyc,
                         input int rd, input int wr, input int hit, input int miss,
                         input int bd);
    vecs[i].name = name; vecs[i].ops = ops; vecs[i].hits = hits;
    vecs[i].stall_idx = stall_idx; vecs[i].cyc = cyc;
    vecs[i].rd = rd; vecs[i].wr = wr; vecs[i].hit = hit; vecs[i].miss = miss; vecs[i].bad = bd;
  endtask

  // Pulse start, optionally pulse it again mid-replay, and count cycles to done.
  task automatic run_replay(input int pulse_at, output int n);
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    n = 1;
    check("clr_rd", int'(s_rd), 0);
    check("clr_wr", int'(s_wr), 0);
    check("clr_hit", int'(s_hit) + int'(s_miss) + int'(s_bad), 0);
    check("clr_idx", int'(s_idx), 0);
    check("clr_busy", int'(s_busy), 1);
    check("clr_done", int'(s_done), 0);
    while (!s_done && n < 200) begin
      s_start = (n == pulse_at);
      @(posedge clk); #1;
      n++;
    end
    s_start = 1'b0;
    check("done_reached", int'(s_done), 1);
  endtask

  task automatic check_counts(input string tag, input int rd, input int wr, input int hit,
                              input int miss, input int bd);
    check({tag, "_rd"}, int'(s_rd), rd);
    check({tag, "_wr"}, int'(s_wr), wr);
    check({tag, "_hit"}, int'(s_hit), hit);
    check({tag, "_miss"}, int'(s_miss), miss);
    check({tag, "_bad"}, int'(s_bad), bd);
  endtask

  initial begin
    int n;
    rst = 1'b1; s_start = 1'b0; b_start = 1'b0;
    s_ops = '0; s_hits = '0; s_lat = 1; s_stall_idx = -1; s_stall_left = 0; s_req_seen = 0;

    //          name      ops (entry 3..0)                   hits    stall cyc rd wr hit miss bad
    set_vec(0, "rwrw",   {8'h57, 8'h52, 8'h57, 8'h52}, 4'b0101, -1, 13, 2, 2, 2, 2, 0);
    set_vec(1, "stall",  {8'h57, 8'h52, 8'h57, 8'h52}, 4'b0101,  1, 18, 2, 2, 2, 2, 0);
    set_vec(2, "badop",  {8'h57, 8'h41, 8'h57, 8'h52}, 4'b1111, -1, 11, 1, 2, 3, 0, 1);
    set_vec(3, "allw",   {8'h57, 8'h57, 8'h57, 8'h57}, 4'b0000, -1, 13, 0, 4, 0, 4, 0);
    set_vec(4, "allbad", {8'h41, 8'h00, 8'hFF, 8'h72}, 4'b0000, -1,  5, 0, 0, 0, 0, 4);

    repeat (2) @(posedge clk);
    #1;
    check("rst_idx", int'(s_idx), 0);
    check("rst_valid", int'(s_bus.req_valid), 0);
    check("rst_write", int'(s_bus.req_write), 0);
    check("rst_addr", int'(s_bus.req_addr), 0);
    check("rst_busy", int'(s_busy), 0);
    check("rst_done", int'(s_done), 0);
    check_counts("rst", 0, 0, 0, 0, 0);
    check("rst_b_idx", int'(b_idx), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      s_ops = vecs[i].ops; s_hits = vecs[i].hits; s_lat = 1; s_timer = 0;
      s_stall_idx = vecs[i].stall_idx; s_stall_left = 5; s_req_seen = 0;
      run_replay(0, n);
      check({vecs[i].name, "_cycles"}, n, vecs[i].cyc);
      check({vecs[i].name, "_reqs"}, s_req_seen, vecs[i].rd + vecs[i].wr);
      check_counts(vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].hit, vecs[i].miss, vecs[i].bad);
      check({vecs[i].name, "_idx_end"}, int'(s_idx), 3);
    end

    // Reset while waiting for the response of entry 1; the late response must be ignored.
    s_ops = vecs[0].ops; s_hits = vecs[0].hits; s_lat = 10; s_timer = 0;
    s_stall_idx = -1; s_req_seen = 0;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    n = 0;
    while (!(int'(s_idx) == 1 && int'(s_rd) + int'(s_wr) == 2) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("rstmid_reached_wait", int'(s_bus.req_valid) + int'(n < 100), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid_valid", int'(s_bus.req_valid), 0);
    check("rstmid_idx", int'(s_idx), 0);
    check("rstmid_busy", int'(s_busy), 0);
    check("rstmid_done", int'(s_done), 0);
    check_counts("rstmid", 0, 0, 0, 0, 0);
    repeat (12) @(posedge clk);
    #1;
    check("rstmid_late_busy", int'(s_busy), 0);
    check_counts("rstmid_late", 0, 0, 0, 0, 0);
    s_timer = 0; s_lat = 1;

    // Start pulsed while busy has no effect; start at DONE replays identically.
    s_req_seen = 0;
    run_replay(4, n);
    check("busy_start_cycles", n, 13);
    check_counts("busy_start", 2, 2, 2, 2, 0);
    run_replay(0, n);
    check("restart_cycles", n, 13);
    check_counts("restart", 2, 2, 2, 2, 0);
    check("restart_reqs", s_req_seen, 8);

    // Full 1000-entry replay against the random responder.
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    n = 0;
    while (!b_done && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    check("big_done", int'(b_done), 1);
    check("big_idx_end", int'(b_idx), 999);
    check("big_reqs", b_reqs, 1000);
    check("big_resps", b_resps, 1000);
    check("big_rd", int'(b_rd), 666);
    check("big_wr", int'(b_wr), 334);
    check("big_hit", int'(b_hit), b_hits_exp);
    check("big_miss", int'(b_miss), 1000 - b_hits_exp);
    check("big_bad", int'(b_bad), 0);
    check("big_req_resp_eq", int'(b_hit) + int'(b_miss), int'(b_rd) + int'(b_wr));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
